// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header: strips N leading bytes per packet and realigns the payload onto full output beats
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    ready_strip,
    output logic                    drop_pulse
);
    localparam int CW = $clog2(DATA_WD) + 1;
    localparam logic [CW-1:0] WB = CW'(DATA_BYTE_WD);

    typedef enum logic [1:0] {S_HEAD, S_BODY, S_FLUSH} state_t;

    state_t             state, state_nxt;
    logic [DATA_WD-1:0] residue, residue_nxt, emit_data, head_shift, body_word, body_res;
    logic [CW-1:0]      r_cnt, r_nxt, emit_cnt, n, v, tot;
    logic               can_emit, emit, emit_last, drop;

    function automatic logic [CW-1:0] popc(input logic [DATA_BYTE_WD-1:0] k);
        popc = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) popc = popc + CW'(k[i]);
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] kmask(input logic [CW-1:0] c);
        kmask = ~({DATA_BYTE_WD{1'b1}} >> c);
    endfunction

    function automatic logic [DATA_WD-1:0] lanes(input logic [DATA_BYTE_WD-1:0] k);
        for (int i = 0; i < DATA_BYTE_WD; i++) lanes[i*8 +: 8] = {8{k[i]}};
    endfunction

    assign can_emit   = !valid_out || ready_out;
    assign n          = CW'(byte_strip_cnt) + CW'(1);
    assign v          = last_in ? popc(keep_in) : WB;
    assign tot        = r_cnt + v;
    assign head_shift = data_in << {n, 3'b000};
    assign body_word  = residue | (data_in >> {r_cnt, 3'b000});
    assign body_res   = data_in << {WB - r_cnt, 3'b000};

    // next-state, handshakes and the beat to load into the output register
    always_comb begin
        state_nxt   = state;
        residue_nxt = residue;
        r_nxt       = r_cnt;
        emit        = 1'b0;
        emit_data   = body_word;
        emit_cnt    = WB;
        emit_last   = 1'b0;
        drop        = 1'b0;
        ready_in    = 1'b0;
        ready_strip = 1'b0;
        case (state)
            S_HEAD: begin
                ready_in    = rst_n && valid_strip && valid_in && can_emit;
                ready_strip = ready_in;
                if (ready_in) begin
                    if (!last_in) begin
                        residue_nxt = head_shift;
                        r_nxt       = WB - n;
                        state_nxt   = S_BODY;
                    end else if (v > n) begin
                        emit      = 1'b1;
                        emit_data = head_shift;
                        emit_cnt  = v - n;
                        emit_last = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            S_BODY: begin
                ready_in = rst_n && can_emit;
                if (ready_in && valid_in) begin
                    emit = 1'b1;
                    if (!last_in) begin
                        residue_nxt = body_res;
                    end else if (tot <= WB) begin
                        emit_cnt  = tot;
                        emit_last = 1'b1;
                        state_nxt = S_HEAD;
                    end else begin
                        residue_nxt = body_res;
                        r_nxt       = tot - WB;
                        state_nxt   = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (can_emit) begin
                    emit      = 1'b1;
                    emit_data = residue;
                    emit_cnt  = r_cnt;
                    emit_last = 1'b1;
                    state_nxt = S_HEAD;
                end
            end
            default: state_nxt = S_HEAD;
        endcase
    end

    // packet state and residue bytes carried between beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_HEAD;
            residue <= '0;
            r_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            residue <= residue_nxt;
            r_cnt   <= r_nxt;
        end
    end

    // registered output beat; invalid lanes are zeroed on load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            keep_out   <= '0;
            last_out   <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= drop;
            if (can_emit) begin
                valid_out <= emit;
                if (emit) begin
                    data_out  <= emit_data & lanes(kmask(emit_cnt));
                    keep_out  <= kmask(emit_cnt);
                    last_out  <= emit_last;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_stream_strip_header.sv
// tb_axi_stream_strip_header: directed scoreboard bench for the header-strip stage
module tb_axi_stream_strip_header;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in, last_in, ready_in, valid_out, last_out, ready_out;
    logic        valid_strip, ready_strip, drop_pulse;
    logic [31:0] data_in, data_out;
    logic [3:0]  keep_in, keep_out;
    logic [1:0]  byte_strip_cnt;

    typedef struct packed {
        logic        drop;
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    axi_stream_strip_header dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
        .valid_strip(valid_strip), .byte_strip_cnt(byte_strip_cnt), .ready_strip(ready_strip),
        .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, need %h", name, act, req);
        end
    endtask

    function automatic void exp_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        q.push_back('{1'b0, d, k, l});
    endfunction

    function automatic void exp_drop();
        q.push_back('{1'b1, 32'h0, 4'h0, 1'b0});
    endfunction

    // one beat, held until accepted; entered and left at posedge+1
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l,
                        input logic s, input logic [1:0] c, input int gap);
        int  t;
        logic acc;
        repeat (gap) begin @(posedge clk); #1; end
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
        valid_strip = s; byte_strip_cnt = c;
        t = 0; acc = 1'b0;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = ready_in;
            @(posedge clk); #1;
            t++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: beat %h not accepted, need accept within 50 cycles", d);
        end
        valid_in = 1'b0; valid_strip = 1'b0; last_in = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin @(posedge clk); t++; end
        #1;
        check("drain_queue", 64'(q.size()), 64'd0);
    endtask

    task automatic send_p1();
        exp_beat(32'h22334455, 4'hF, 1'b0);
        exp_beat(32'h66778899, 4'hF, 1'b0);
        exp_beat(32'hAA000000, 4'h8, 1'b1);
        send(32'h00112233, 4'hF, 1'b0, 1'b1, 2'd1, 0);
        send(32'h44556677, 4'hF, 1'b0, 1'b0, 2'd0, 0);
        send(32'h8899AA55, 4'hE, 1'b1, 1'b0, 2'd0, 0);
    endtask

    // scoreboard monitor: each presented beat or drop pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (drop_pulse) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_drop: got drop_pulse, need nothing pending");
                end else begin
                    e = q.pop_front();
                    check("drop_expected", 64'(e.drop), 64'd1);
                end
            end
            if (valid_out && ready_out) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_beat: got %h keep %h last %b, need no beat", data_out, keep_out, last_out);
                end else begin
                    e = q.pop_front();
                    check("beat_not_drop", 64'(e.drop), 64'd0);
                    if (!e.drop) begin
                        check("data", 64'(data_out), 64'(e.d));
                        check("keep", 64'(keep_out), 64'(e.k));
                        check("last", 64'(last_out), 64'(e.l));
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] held;
        int t;
        valid_in = 1'b1; valid_strip = 1'b1; ready_out = 1'b1;
        data_in = 32'hDEADBEEF; keep_in = 4'hF; last_in = 1'b0; byte_strip_cnt = 2'd0;
        #3;
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_keep_out", 64'(keep_out), 64'd0);
        check("rst_last_out", 64'(last_out), 64'd0);
        check("rst_drop", 64'(drop_pulse), 64'd0);
        check("rst_ready_in", 64'(ready_in), 64'd0);
        check("rst_ready_strip", 64'(ready_strip), 64'd0);
        valid_in = 1'b0; valid_strip = 1'b0;
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        send_p1();

        exp_beat(32'h22334455, 4'hF, 1'b0);
        exp_beat(32'h66778899, 4'hF, 1'b1);
        send(32'h00112233, 4'hF, 1'b0, 1'b1, 2'd1, 0);
        send(32'h44556677, 4'hF, 1'b0, 1'b0, 2'd0, 0);
        send(32'h88997711, 4'hC, 1'b1, 1'b0, 2'd0, 0);

        exp_beat(32'h44556677, 4'hF, 1'b0);
        exp_beat(32'h8899AA00, 4'hE, 1'b1);
        send(32'h00112233, 4'hF, 1'b0, 1'b1, 2'd3, 0);
        send(32'h44556677, 4'hF, 1'b0, 1'b0, 2'd0, 0);
        send(32'h8899AA55, 4'hE, 1'b1, 1'b0, 2'd0, 0);

        exp_beat(32'h22330000, 4'hC, 1'b1);
        send(32'h112233EE, 4'hE, 1'b1, 1'b1, 2'd0, 0);
        exp_drop();
        send(32'h11ABCDEF, 4'h8, 1'b1, 1'b1, 2'd0, 0);
        exp_drop();
        send(32'h01020304, 4'hF, 1'b1, 1'b1, 2'd3, 0);
        exp_beat(32'h55000000, 4'h8, 1'b1);
        send(32'h44557766, 4'hC, 1'b1, 1'b1, 2'd0, 1);
        drain();

        exp_beat(32'h11223344, 4'hF, 1'b0);
        exp_beat(32'h55667788, 4'hF, 1'b0);
        exp_beat(32'h99AABBCC, 4'hF, 1'b0);
        exp_beat(32'hDDEEFF00, 4'hE, 1'b1);
        fork
            begin
                send(32'h00112233, 4'hF, 1'b0, 1'b1, 2'd0, int'($urandom_range(0, 2)));
                send(32'h44556677, 4'hF, 1'b0, 1'b0, 2'd0, int'($urandom_range(0, 2)));
                send(32'h8899AABB, 4'hF, 1'b0, 1'b0, 2'd0, int'($urandom_range(0, 2)));
                send(32'hCCDDEEFF, 4'hF, 1'b1, 1'b0, 2'd0, int'($urandom_range(0, 2)));
            end
            begin
                t = 0;
                do begin @(posedge clk); #1; t++; end while (!valid_out && t < 30);
                check("bp_valid_seen", 64'(valid_out), 64'd1);
                ready_out = 1'b0;
                held = data_out;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_ready_in", 64'(ready_in), 64'd0);
                    check("bp_valid_held", 64'(valid_out), 64'd1);
                    check("bp_data_held", 64'(data_out), 64'(held));
                    @(posedge clk); #1;
                end
                ready_out = 1'b1;
            end
        join
        drain();

        ready_out = 1'b0;
        send(32'h00112233, 4'hF, 1'b0, 1'b1, 2'd1, 0);
        send(32'h44556677, 4'hF, 1'b0, 1'b0, 2'd0, 0);
        #2;
        check("pre_rst_valid_out", 64'(valid_out), 64'd1);
        valid_in = 1'b1; valid_strip = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid_out", 64'(valid_out), 64'd0);
        check("mid_rst_data_out", 64'(data_out), 64'd0);
        check("mid_rst_keep_out", 64'(keep_out), 64'd0);
        check("mid_rst_last_out", 64'(last_out), 64'd0);
        check("mid_rst_drop", 64'(drop_pulse), 64'd0);
        check("mid_rst_ready_in", 64'(ready_in), 64'd0);
        check("mid_rst_ready_strip", 64'(ready_strip), 64'd0);
        valid_in = 1'b0; valid_strip = 1'b0; ready_out = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_p1();
        drain();
        repeat (5) @(posedge clk);
        check("final_queue", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
